// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht
//   Dynamic branch predictor built from a table of 2**IDX_W saturating
//   counters. Fetch reads a prediction with no latency. Execute writes back
//   the resolved direction and flags mispredictions for the hazard unit.
//   Resolved-branch and mispredict statistics are kept as saturating counters.
//
//   Optional feature: define GSHARE_EN to add a global history register.
//   The history is XORed into both the lookup index and the update index.
//   Without GSHARE_EN the predictor is bimodal (PC bits only) and ghr_F = 0.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   lookup_valid_F     fetch lookup is real (advances speculative history)
//   lookup_pc_F        fetch PC
//   prediction_F       predicted taken (combinational)
//   ghr_F              history snapshot to carry down the pipe
//   update_signal_E    branch resolved this cycle
//   update_pc_E        PC of the resolved branch
//   ghr_E              history snapshot carried with the branch
//   prediction_E       prediction carried with the branch
//   actual_outcome_E   resolved direction
//   mispredict_E       resolved branch disagreed with its prediction
//   branch_count       resolved branches since reset (saturating)
//   mispredict_count   mispredictions since reset (saturating)
// ---------------------------------------------------------------------------

// One table entry: an up/down counter that saturates at both ends.
module bht_ctr #(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  output logic [CTR_W-1:0] ctr
);
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_W-1:0] INIT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] MAX  = '1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctr <= INIT;
    end else if (en) begin
      if (up) begin
        if (ctr != MAX) ctr <= ctr + CTR_W'(1);
      end else begin
        if (ctr != '0) ctr <= ctr - CTR_W'(1);
      end
    end
  end
endmodule

module branch_predictor_bht #(
  parameter int PC_W   = 32,
  parameter int PC_LSB = 0,
  parameter int IDX_W  = 4,
  parameter int CTR_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_valid_F,
  input  logic [PC_W-1:0]   lookup_pc_F,
  output logic              prediction_F,
  output logic [IDX_W-1:0]  ghr_F,
  input  logic              update_signal_E,
  input  logic [PC_W-1:0]   update_pc_E,
  input  logic [IDX_W-1:0]  ghr_E,
  input  logic              prediction_E,
  input  logic              actual_outcome_E,
  output logic              mispredict_E,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);
  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0][CTR_W-1:0] tbl;
  logic [IDX_W-1:0]              lidx;
  logic [IDX_W-1:0]              uidx;
  logic                          unused_ok;

  assign mispredict_E = update_signal_E & (prediction_E ^ actual_outcome_E);

`ifdef GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  assign lidx  = lookup_pc_F[PC_LSB +: IDX_W] ^ ghr_q;
  assign uidx  = update_pc_E[PC_LSB +: IDX_W] ^ ghr_E;
  assign ghr_F = ghr_q;
  assign unused_ok = ^{lookup_pc_F, update_pc_E, ghr_E[IDX_W-1]};

  // Repair from the carried snapshot beats the speculative shift: the
  // shifted-in prediction belongs to a path that is being flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              ghr_q <= '0;
    else if (mispredict_E)   ghr_q <= {ghr_E[IDX_W-2:0], actual_outcome_E};
    else if (lookup_valid_F) ghr_q <= {ghr_q[IDX_W-2:0], prediction_F};
  end
`else
  assign lidx  = lookup_pc_F[PC_LSB +: IDX_W];
  assign uidx  = update_pc_E[PC_LSB +: IDX_W];
  assign ghr_F = '0;
  assign unused_ok = ^{lookup_pc_F, update_pc_E, ghr_E, lookup_valid_F};
`endif

  // Read path is purely combinational; a same-cycle update to the same entry
  // is not bypassed, so the lookup sees the pre-update value.
  assign prediction_F = tbl[lidx][CTR_W-1];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    bht_ctr #(.CTR_W(CTR_W)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .en    (update_signal_E && (uidx == IDX_W'(i))),
      .up    (actual_outcome_E),
      .ctr   (tbl[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (update_signal_E && branch_count != '1)
        branch_count <= branch_count + STAT_W'(1);
      if (mispredict_E && mispredict_count != '1)
        mispredict_count <= mispredict_count + STAT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;
  localparam int PC_W   = 32;
  localparam int PC_LSB = 0;
  localparam int IDX_W  = 4;
  localparam int CTR_W  = 2;
  localparam int STAT_W = 6;   // small so statistic saturation is reachable
  localparam int ENT    = 1 << IDX_W;
  localparam int CMAX   = (1 << CTR_W) - 1;
  localparam int CINIT  = (1 << (CTR_W - 1)) - 1;
  localparam int HALF   = 1 << (CTR_W - 1);
  localparam int SMAX   = (1 << STAT_W) - 1;
`ifdef GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              lookup_valid_F = 1'b0;
  logic [PC_W-1:0]   lookup_pc_F = '0;
  logic              prediction_F;
  logic [IDX_W-1:0]  ghr_F;
  logic              update_signal_E = 1'b0;
  logic [PC_W-1:0]   update_pc_E = '0;
  logic [IDX_W-1:0]  ghr_E = '0;
  logic              prediction_E = 1'b0;
  logic              actual_outcome_E = 1'b0;
  logic              mispredict_E;
  logic [STAT_W-1:0] branch_count;
  logic [STAT_W-1:0] mispredict_count;

  always #5 clk = ~clk;

  branch_predictor_bht #(
    .PC_W(PC_W), .PC_LSB(PC_LSB), .IDX_W(IDX_W), .CTR_W(CTR_W), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .lookup_valid_F(lookup_valid_F), .lookup_pc_F(lookup_pc_F),
    .prediction_F(prediction_F), .ghr_F(ghr_F),
    .update_signal_E(update_signal_E), .update_pc_E(update_pc_E),
    .ghr_E(ghr_E), .prediction_E(prediction_E),
    .actual_outcome_E(actual_outcome_E), .mispredict_E(mispredict_E),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  // ---------------- reference model (plain integer arithmetic) -------------
  typedef struct { int pred; int ghr; int mis; int bc; int mc; } exp_t;
  exp_t sbq[$];
  int mtbl[ENT];
  int mghr, mbc, mmc;
  int checks = 0, errors = 0;

  function automatic int pidx(input logic [PC_W-1:0] pc, input int g);
    int base;
    base = int'((pc >> PC_LSB) & (ENT - 1));
    return GS ? (base ^ g) : base;
  endfunction

  function automatic void model_reset();
    foreach (mtbl[i]) mtbl[i] = CINIT;
    mghr = 0; mbc = 0; mmc = 0;
  endfunction

  function automatic void chk(input string n, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, expv, $time);
    end
  endfunction

  // Sets inputs shortly after an edge, pushes the outputs expected during this
  // cycle, then advances the model to the state after the next edge.
  task automatic drive(input bit lv, input logic [PC_W-1:0] lpc, input bit upd,
                       input logic [PC_W-1:0] upc, input int ghre, input bit pe,
                       input bit act, input bit apply = 1'b1);
    exp_t e;
    int li, ui, p, mis;
    @(posedge clk); #1;
    lookup_valid_F = lv; lookup_pc_F = lpc; update_signal_E = upd;
    update_pc_E = upc; ghr_E = IDX_W'(ghre); prediction_E = pe;
    actual_outcome_E = act;
    li  = pidx(lpc, mghr);
    p   = (mtbl[li] >= HALF) ? 1 : 0;
    mis = (upd && (pe != act)) ? 1 : 0;
    e.pred = p; e.ghr = GS ? mghr : 0; e.mis = mis; e.bc = mbc; e.mc = mmc;
    sbq.push_back(e);
    if (apply) begin
      if (upd) begin
        ui = pidx(upc, ghre);
        mtbl[ui] = act ? ((mtbl[ui] + 1 > CMAX) ? CMAX : mtbl[ui] + 1)
                       : ((mtbl[ui] - 1 < 0) ? 0 : mtbl[ui] - 1);
        if (mbc < SMAX) mbc++;
        if (mis && mmc < SMAX) mmc++;
      end
      if (GS) begin
        if (mis)     mghr = ((ghre << 1) | act) & (ENT - 1);
        else if (lv) mghr = ((mghr << 1) | p) & (ENT - 1);
      end
    end
  endtask

  task automatic idle(); drive(0, '0, 0, '0, 0, 0, 0); endtask

  // ---------------- monitor ------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("prediction_F", int'(prediction_F), e.pred);
      chk("ghr_F", int'(ghr_F), e.ghr);
      chk("mispredict_E", int'(mispredict_E), e.mis);
      chk("branch_count", int'(branch_count), e.bc);
      chk("mispredict_count", int'(mispredict_count), e.mc);
    end
  end

  // ---------------- stimulus -----------------------------------------------
  initial begin
    exp_t e;
    model_reset();
    // Reset: outputs at reset values, mispredict_E still follows inputs,
    // and an update presented during reset must not land.
    drive(1, 32'd3, 1, 32'd3, 0, 0, 1, 0);
    idle();
    #1 reset = 1'b1;

    // 1: every index predicts not-taken after reset
    for (int i = 0; i < ENT; i++) drive(1, PC_W'(i), 0, '0, 0, 0, 0);

    // 2: pc 3 taken x2 -> taken; x3 stays saturated; one not-taken still taken
    for (int i = 0; i < 3; i++) drive(0, '0, 1, 32'd3, mghr, 1, 1);
    drive(1, 32'd3, 1, 32'd3, mghr, 1, 0);
    drive(1, 32'd3, 0, '0, 0, 0, 0);
    chk("pc3_taken_after_dec", int'(prediction_F), 1);

    // 3: five taken updates carrying the then-current prediction
    for (int i = 0; i < 5; i++)
      drive(0, '0, 1, 32'd9, 0, (mtbl[pidx(32'd9, 0)] >= HALF), 1);
    idle();

    // 4: same-cycle lookup and update of index 5, then lookup again
    drive(1, 32'd5, 1, 32'd5, mghr, 0, 1);
    drive(1, 32'd5, 1, 32'd5, mghr, 1, 1);
    drive(1, 32'd5, 0, '0, 0, 0, 0);

    // 5: reset asserted mid-update on the third taken update of pc 3
    for (int i = 0; i < 2; i++) drive(0, '0, 1, 32'd3, 0, 1, 1);
    @(posedge clk); #1;
    lookup_valid_F = 1; lookup_pc_F = 32'd3; update_signal_E = 1;
    update_pc_E = 32'd3; ghr_E = '0; prediction_E = 1; actual_outcome_E = 1;
    #1 reset = 1'b0;
    model_reset();
    e.pred = 0; e.ghr = 0; e.mis = 0; e.bc = 0; e.mc = 0;
    sbq.push_back(e);
    @(posedge clk); #1;
    lookup_valid_F = 0; update_signal_E = 0;
    reset = 1'b1;
    for (int i = 0; i < ENT; i++) drive(1, PC_W'(i), 0, '0, 0, 0, 0);

`ifdef GSHARE_EN
    // 6: train all entries taken without disturbing history, then three
    // predicted-taken lookups and a same-cycle repair.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < ENT; i++) drive(0, '0, 1, PC_W'(i), 0, 1, 1);
    for (int i = 0; i < 3; i++) drive(1, PC_W'(i), 0, '0, 0, 0, 0);
    drive(1, 32'd1, 1, 32'd6, 2, 1, 0);
    idle();
    chk("gshare_repair_ghr", int'(ghr_F), 4);
`endif

    // Random traffic with frequent PC collisions; drives stats to saturation.
    for (int n = 0; n < 600; n++) begin
      logic [PC_W-1:0] lpc, upc;
      lpc = $urandom;
      upc = ($urandom_range(0, 1) != 0) ? lpc : PC_W'($urandom);
      drive($urandom_range(0, 1), lpc, $urandom_range(0, 3) != 0, upc,
            int'($urandom_range(0, ENT - 1)), $urandom_range(0, 1),
            $urandom_range(0, 1));
    end
    idle();
    chk("branch_count_saturated", int'(branch_count), SMAX);
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
